// File: rtl/mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : mem_boot_loader
// Brief   : Framed byte-stream loader that fills instruction/data BRAMs with
//           little-endian words, then releases the CPU on a run command.
// Revision: 1.0 - initial release
// ============================================================================
module mem_boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          MAX_WORDS  = 256,
    parameter logic [7:0]  CMD_INSTR  = 8'hA5,
    parameter logic [7:0]  CMD_DATA   = 8'h5A,
    parameter logic [7:0]  CMD_RUN    = 8'hC3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  pc_stall,
    output logic                  d_bram_init_done,
    output logic                  load_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_CNT_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_WRITE   = 3'd4,
        ST_CHKSUM  = 3'd5,
        ST_ERROR   = 3'd6,
        ST_RUN     = 3'd7
    } state_t;

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_s_ready;
    logic                    w_s_ready_next;
    logic                    r_target_data;
    logic [7:0]              r_cnt_lo;
    logic [15:0]             r_count;
    logic [15:0]             r_index;
    logic [1:0]              r_byte_cnt;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [7:0]              r_chksum;
    logic [ADDR_WIDTH-1:0]   r_i_addr;
    logic [DATA_WIDTH-1:0]   r_i_dat;
    logic [ADDR_WIDTH-1:0]   r_d_addr;
    logic [DATA_WIDTH-1:0]   r_d_dat;

    logic                    w_xfer;
    logic                    w_is_load_cmd;
    logic [15:0]             w_count;
    logic [15:0]             w_index_inc;
    logic [DATA_WIDTH-1:0]   w_word_shifted;
    logic [ADDR_WIDTH-1:0]   w_word_addr;

    assign w_xfer         = s_valid && r_s_ready;
    assign w_is_load_cmd  = (s_data == CMD_INSTR) || (s_data == CMD_DATA);
    assign w_count        = {s_data, r_cnt_lo};
    assign w_index_inc    = r_index + 16'd1;
    // Bytes enter at the top so the first byte ends up in [7:0].
    assign w_word_shifted = {s_data, r_word[DATA_WIDTH-1:8]};
    assign w_word_addr    = ADDR_WIDTH'({r_index, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_is_load_cmd)          w_next_state = ST_CNT_LO;
                    else if (s_data == CMD_RUN) w_next_state = ST_RUN;
                end
            end
            ST_CNT_LO:  if (w_xfer) w_next_state = ST_CNT_HI;
            ST_CNT_HI: begin
                if (w_xfer) begin
                    if ({1'b0, w_count} > c_max_words) w_next_state = ST_ERROR;
                    else if (w_count == 16'd0)         w_next_state = ST_CHKSUM;
                    else                               w_next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (w_xfer && (r_byte_cnt == 2'd3)) w_next_state = ST_WRITE;
            ST_WRITE:   w_next_state = (w_index_inc == r_count) ? ST_CHKSUM : ST_PAYLOAD;
            ST_CHKSUM: begin
                if (w_xfer) w_next_state = (s_data == r_chksum) ? ST_IDLE : ST_ERROR;
            end
            ST_ERROR:   w_next_state = ST_ERROR;
            ST_RUN:     w_next_state = ST_RUN;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Ready is registered from the next state so it is glitch-free at the port.
    assign w_s_ready_next = (w_next_state == ST_IDLE)    || (w_next_state == ST_CNT_LO) ||
                            (w_next_state == ST_CNT_HI)  || (w_next_state == ST_PAYLOAD) ||
                            (w_next_state == ST_CHKSUM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_ready     <= 1'b0;
            r_target_data <= 1'b0;
            r_cnt_lo      <= '0;
            r_count       <= '0;
            r_index       <= '0;
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_chksum      <= '0;
            r_i_addr      <= '0;
            r_i_dat       <= '0;
            r_d_addr      <= '0;
            r_d_dat       <= '0;
        end else begin
            r_s_ready <= w_s_ready_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && w_is_load_cmd) begin
                        r_target_data <= (s_data == CMD_DATA);
                        r_chksum      <= '0;
                        r_index       <= '0;
                        r_byte_cnt    <= '0;
                    end
                end
                ST_CNT_LO: if (w_xfer) r_cnt_lo <= s_data;
                ST_CNT_HI: if (w_xfer) r_count  <= w_count;
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_word     <= w_word_shifted;
                        r_chksum   <= r_chksum ^ s_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Only the selected target's port moves; the other holds.
                        if (r_byte_cnt == 2'd3) begin
                            if (r_target_data) begin
                                r_d_addr <= w_word_addr;
                                r_d_dat  <= w_word_shifted;
                            end else begin
                                r_i_addr <= w_word_addr;
                                r_i_dat  <= w_word_shifted;
                            end
                        end
                    end
                end
                ST_WRITE: r_index <= w_index_inc;
                default: ;
            endcase
        end
    end

    assign s_ready          = r_s_ready;
    assign i_w_addr         = r_i_addr;
    assign i_w_dat          = r_i_dat;
    assign i_w_enb          = (r_state == ST_WRITE) && !r_target_data;
    assign d_w_addr         = r_d_addr;
    assign d_w_dat          = r_d_dat;
    assign d_w_enb          = (r_state == ST_WRITE) && r_target_data;
    assign pc_stall         = (r_state != ST_RUN);
    assign d_bram_init_done = (r_state == ST_RUN);
    assign load_err         = (r_state == ST_ERROR);
    assign busy             = (r_state != ST_IDLE) && (r_state != ST_RUN) && (r_state != ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_boot_loader
// Brief   : Scoreboard bench for mem_boot_loader framing, writes and errors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  i_w_addr;
    logic [31:0] i_w_dat;
    logic        i_w_enb;
    logic [9:0]  d_w_addr;
    logic [31:0] d_w_dat;
    logic        d_w_enb;
    logic        pc_stall;
    logic        d_bram_init_done;
    logic        load_err;
    logic        busy;

    typedef struct {
        bit          tgt_data;
        logic [9:0]  addr;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] wbuf[256];
    int          n_compared;
    int          n_mismatched;

    mem_boot_loader dut (
        .clk              (clk),
        .rst              (rst),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .pc_stall         (pc_stall),
        .d_bram_init_done (d_bram_init_done),
        .load_err         (load_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every enable pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && (i_w_enb || d_w_enb)) begin
            if (sb.size() == 0) begin
                check_val("unexpected_wr", {62'd0, i_w_enb, d_w_enb}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("wr_enb", {62'd0, i_w_enb, d_w_enb}, mon_e.tgt_data ? 64'd1 : 64'd2);
                check_val("wr_addr", mon_e.tgt_data ? d_w_addr : i_w_addr, mon_e.addr);
                check_val("wr_dat", mon_e.tgt_data ? d_w_dat : i_w_dat, mon_e.dat);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check_val("ready_timeout", 64'd1, 64'd0);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 s_valid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        check_val("rst_pc_stall", pc_stall, 1'b1);
        check_val("rst_outs", {i_w_enb, d_w_enb, load_err, busy, d_bram_init_done, s_ready}, 6'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_ready_up", s_ready, 1'b1);
    endtask

    task automatic load_section(input logic [7:0] cmd, input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] by;
        exp_t       e;
        x = 8'h00;
        send_byte(cmd);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int k = 0; k < n; k++) begin
            e.tgt_data = (cmd == 8'h5A);
            e.addr     = 10'(k * 4);
            e.dat      = wbuf[k];
            sb.push_back(e);
            for (int b = 0; b < 4; b++) begin
                by = wbuf[k][8*b +: 8];
                x  = x ^ by;
                send_byte(by);
            end
        end
        send_byte(corrupt ? (x ^ 8'hFF) : x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_data       = 8'h00;

        // 1: instruction section, three words
        apply_reset();
        wbuf[0] = 32'h00500293;
        wbuf[1] = 32'h00802303;
        wbuf[2] = 32'h0062A023;
        load_section(8'hA5, 3, 1'b0);
        repeat (3) @(negedge clk);
        check_val("t1_pending", sb.size(), 0);
        check_val("t1_load_err", load_err, 1'b0);
        check_val("t1_pc_stall", pc_stall, 1'b1);
        check_val("t1_idle", {busy, s_ready}, 2'b01);

        // 2: data section then run
        for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
        load_section(8'h5A, 4, 1'b0);
        send_byte(8'hC3);
        repeat (2) @(negedge clk);
        check_val("t2_pending", sb.size(), 0);
        check_val("t2_run", {pc_stall, d_bram_init_done, s_ready, busy, load_err}, 5'b01000);

        // 3: bad checksum after one word
        apply_reset();
        wbuf[0] = 32'hDEADBEEF;
        load_section(8'hA5, 1, 1'b1);
        repeat (2) @(negedge clk);
        check_val("t3_pending", sb.size(), 0);
        check_val("t3_err", {load_err, pc_stall, s_ready, busy}, 4'b1100);
        repeat (5) @(negedge clk);
        check_val("t3_err_sticky", load_err, 1'b1);

        // 4: count over limit, then exactly at limit
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        check_val("t4_err", {load_err, s_ready, busy}, 3'b100);
        repeat (3) @(negedge clk);
        check_val("t4_pending", sb.size(), 0);
        apply_reset();
        for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
        load_section(8'h5A, 256, 1'b0);
        repeat (3) @(negedge clk);
        check_val("t4_max_pending", sb.size(), 0);
        check_val("t4_max_ok", {load_err, busy, s_ready}, 3'b001);

        // 5: empty section, unknown byte, then a load still works
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check_val("t5_empty", {load_err, busy, s_ready}, 3'b001);
        send_byte(8'h77);
        @(negedge clk);
        check_val("t5_ignore", {load_err, busy, s_ready, pc_stall}, 4'b0011);
        wbuf[0] = 32'h12345678;
        load_section(8'hA5, 1, 1'b0);
        repeat (3) @(negedge clk);
        check_val("t5_pending", sb.size(), 0);
        check_val("t5_load_err", load_err, 1'b0);

        // 6: gappy payload then async reset mid-word
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        repeat (3) @(negedge clk);
        send_byte(8'h22);
        @(negedge clk);
        check_val("t6_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_val("t6_async", {pc_stall, s_ready, busy, i_w_enb, d_w_enb, load_err, d_bram_init_done}, 7'b1000000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t6_pending", sb.size(), 0);
        check_val("t6_idle", {busy, s_ready, load_err}, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
